// File: rtl/arith_pkg.sv
// Shared definitions for the lab arithmetic datapath: divider state encoding
// and sizing helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    // Iteration counter width, CNT_W = $clog2(WIDTH+1) for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // The shifted value is one bit wider than an operand; after restoring it
    // is always below the divisor, so WIDTH bits suffice for the result.
    logic [WIDTH:0] trial;

    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, divisor_i});
        rem_o = q_o ? WIDTH'(trial - {1'b0, divisor_i}) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// registered results and a single-cycle done pulse.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0] part_q,    part_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             zero_q,    zero_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] quot_q,    quot_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic             dbz_q,     dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (part_q),
        .bit_i    (shift_q[WIDTH-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .q_o      (step_bit)
    );

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        count_d   = count_q;
        part_d    = part_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            IDLE: begin
                // The cycle showing done still belongs to the finishing operation.
                if (start && !done_q) begin
                    divisor_d = divisor;
                    shift_d   = dividend;
                    part_d    = '0;
                    count_d   = '0;
                    zero_d    = (divisor == '0);
                    state_d   = (divisor == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                part_d  = step_rem;
                shift_d = {shift_q[WIDTH-2:0], step_bit};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    // The dividend never left the shift register on this path.
                    quot_d = '1;
                    rem_d  = shift_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = shift_q;
                    rem_d  = part_q;
                    dbz_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            part_q    <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            part_q    <= part_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, multi-cycle corner
// sequences, an exhaustive 4-bit sweep and random 8-bit operands.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4, q4, r4;
    logic [7:0] a8, b8, q8, r8;
    logic       busy4, done4, z4;
    logic       busy8, done8, z8;

    int n_checks = 0;
    int n_err    = 0;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
        int lat;
        int bsy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; divide by zero gives all ones and the dividend.
    function automatic void ref_div(input int w, input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << w) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Pulse start for one edge, wait (bounded) for done, capture results, then
    // confirm done lasted exactly one cycle.
    task automatic run_op(input bit w8, input int a, input int b,
                          output int q, output int r, output int z,
                          output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0];
        end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
        if (w8 ? busy8 : busy4) bsy++;
        while (!(w8 ? done8 : done4) && lat < 40) begin
            tick();
            lat++;
            if (w8 ? busy8 : busy4) bsy++;
        end
        q = w8 ? int'(q8) : int'(q4);
        r = w8 ? int'(r8) : int'(r4);
        z = w8 ? int'(z8) : int'(z4);
        tick();
        check("done_one_cycle", w8 ? done8 : done4, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int q, r, z, lat, bsy, n, eq, er, ez;
        int idle_busy, held_q, seen;

        vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1,  z: 0, lat: 5, bsy: 5};
        vecs[1] = '{a: 7,  b: 0,  q: 15, r: 7,  z: 1, lat: 1, bsy: 1};
        vecs[2] = '{a: 8,  b: 2,  q: 4,  r: 0,  z: 0, lat: 5, bsy: 5};
        vecs[3] = '{a: 15, b: 15, q: 1,  r: 0,  z: 0, lat: 5, bsy: 5};
        vecs[4] = '{a: 0,  b: 5,  q: 0,  r: 0,  z: 0, lat: 5, bsy: 5};
        vecs[5] = '{a: 3,  b: 7,  q: 0,  r: 3,  z: 0, lat: 5, bsy: 5};
        vecs[6] = '{a: 15, b: 0,  q: 15, r: 15, z: 1, lat: 1, bsy: 1};

        rst_n  = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        #1;
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_quotient", q4, 4'd0);
        check("rst_remainder", r4, 4'd0);
        check("rst_dbz", z4, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors, including divide by zero followed by a normal op.
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, q, r, z, lat, bsy);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bsy, vecs[i].bsy);
        end

        // start held high: 15/1 then 2/9; the done cycle's edge is the one idle edge.
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd1;
        tick();
        a4 = 4'd2; b4 = 4'd9;
        n = 0;
        while (!done4 && n < 40) begin tick(); n++; end
        check("b2b_first_latency", n, 5);
        check("b2b_first_q", q4, 4'd15);
        check("b2b_first_r", r4, 4'd0);
        n = 0;
        idle_busy = 1;
        held_q = 0;
        do begin
            tick();
            n++;
            if (n == 1) idle_busy = busy4;
            if (n == 3) held_q = q4;
        end while (!done4 && n < 40);
        start4 = 1'b0;
        check("b2b_done_spacing", n, 7);
        check("b2b_idle_cycle_busy", idle_busy, 0);
        check("b2b_result_held", held_q, 15);
        check("b2b_second_q", q4, 4'd0);
        check("b2b_second_r", r4, 4'd2);
        tick();
        check("b2b_done_one_cycle", done4, 1'b0);

        // start re-pulsed with new operands while busy on 14/5 is ignored.
        start4 = 1'b1; a4 = 4'd14; b4 = 4'd5;
        tick();
        start4 = 1'b0;
        tick();
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd4;
        tick();
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        n = 2;
        while (!done4 && n < 40) begin tick(); n++; end
        check("busy_start_latency", n, 5);
        check("busy_start_q", q4, 4'd2);
        check("busy_start_r", r4, 4'd4);
        check("busy_start_dbz", z4, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4 || busy4) seen++;
        end
        check("busy_start_not_queued", seen, 0);

        // Reset asserted in the second RUN cycle of 12/5.
        start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
        tick();
        start4 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy4, 1'b0);
        check("midrst_done", done4, 1'b0);
        check("midrst_quotient", q4, 4'd0);
        check("midrst_remainder", r4, 4'd0);
        check("midrst_dbz", z4, 1'b0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done4 || busy4) seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 || busy4) seen++;
        end
        check("midrst_no_done", seen, 0);
        run_op(1'b0, 12, 5, q, r, z, lat, bsy);
        check("midrst_after_q", q, 2);
        check("midrst_after_r", r, 2);
        check("midrst_after_latency", lat, 5);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(4, a, b, eq, er, ez);
                run_op(1'b0, a, b, q, r, z, lat, bsy);
                check($sformatf("w4_%0d_%0d_q", a, b), q, eq);
                check($sformatf("w4_%0d_%0d_r", a, b), r, er);
                check($sformatf("w4_%0d_%0d_dbz", a, b), z, ez);
                check($sformatf("w4_%0d_%0d_latency", a, b), lat, (b == 0) ? 1 : 5);
                if (b != 0) begin
                    check($sformatf("w4_%0d_%0d_invariant", a, b),
                          (a == q * b + r) && (r < b), 1);
                end
            end
        end

        // Random 8-bit operands, with a zero divisor forced every 50th pair.
        for (int i = 0; i < 1000; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = (i % 50 == 0) ? 0 : $urandom_range(0, 255);
            ref_div(8, a, b, eq, er, ez);
            run_op(1'b1, a, b, q, r, z, lat, bsy);
            check($sformatf("w8_%0d_%0d_q", a, b), q, eq);
            check($sformatf("w8_%0d_%0d_r", a, b), r, er);
            check($sformatf("w8_%0d_%0d_dbz", a, b), z, ez);
            check($sformatf("w8_%0d_%0d_latency", a, b), lat, (b == 0) ? 1 : 9);
            if (b != 0) begin
                check($sformatf("w8_%0d_%0d_invariant", a, b),
                      (a == q * b + r) && (r < b), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
